// File: rtl/quantize_block_pkg.sv
// Shared constants, FSM state encoding and zigzag scan table for quantize_block.
package quantize_block_pkg;

    localparam int unsigned QFIX      = 17;
    localparam int unsigned MAX_LEVEL = 2047;
    localparam int unsigned QW        = 9;
    localparam int unsigned IQW       = 17;
    localparam int unsigned DQW       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Scan position -> raster source index for a 4x4 block.
    function automatic logic [3:0] zigzag_src(input logic [3:0] k);
        logic [3:0] s;
        case (k)
            4'd0:  s = 4'd0;
            4'd1:  s = 4'd1;
            4'd2:  s = 4'd4;
            4'd3:  s = 4'd8;
            4'd4:  s = 4'd5;
            4'd5:  s = 4'd2;
            4'd6:  s = 4'd3;
            4'd7:  s = 4'd6;
            4'd8:  s = 4'd9;
            4'd9:  s = 4'd12;
            4'd10: s = 4'd13;
            4'd11: s = 4'd10;
            4'd12: s = 4'd7;
            4'd13: s = 4'd11;
            4'd14: s = 4'd14;
            default: s = 4'd15;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quantize_block_quant_coef.sv
// Combinational single-coefficient quantizer: reciprocal multiply, rounding bias,
// level clamp, and saturated dequantization to 16 bits.
module quant_coef
    import quantize_block_pkg::*;
#(
    parameter int unsigned CW = 12
) (
    input  logic signed [CW-1:0]  coef_i,
    input  logic        [QW-1:0]  q_i,
    input  logic        [IQW-1:0] iq_i,
    input  logic        [IQW-1:0] bias_i,
    output logic signed [CW-1:0]  level_o,
    output logic signed [DQW-1:0] dq_o
);

    localparam int unsigned PW  = CW + IQW;
    localparam int unsigned MW  = PW - QFIX + 1;
    localparam int unsigned DMW = CW - 1 + QW;

    logic [CW-1:0]  mag;
    logic [PW-1:0]  prod;
    logic [PW:0]    acc;
    logic [MW-1:0]  m;
    logic [CW-2:0]  mag_lvl;
    logic [CW-1:0]  lvl_u;
    logic [DMW-1:0] dq_mag;
    logic           neg;

    always_comb begin
        neg  = coef_i[CW-1];
        // |-2^(CW-1)| still fits in CW unsigned bits
        mag  = neg ? ($unsigned(~coef_i) + {{(CW-1){1'b0}}, 1'b1}) : $unsigned(coef_i);
        prod = {{IQW{1'b0}}, mag} * {{CW{1'b0}}, iq_i};
        acc  = {1'b0, prod} + {{(PW+1-IQW){1'b0}}, bias_i};
        m    = acc[PW:QFIX];

        if (m > MW'(MAX_LEVEL)) begin
            mag_lvl = (CW-1)'(MAX_LEVEL);
        end else begin
            mag_lvl = m[CW-2:0];
        end
        if (coef_i == '0) begin
            mag_lvl = '0;
        end

        lvl_u   = {1'b0, mag_lvl};
        level_o = neg ? $signed(-lvl_u) : $signed(lvl_u);

        dq_mag = {{QW{1'b0}}, mag_lvl} * {{(CW-1){1'b0}}, q_i};
        if (!neg) begin
            dq_o = (dq_mag > DMW'(32767)) ? 16'sh7FFF : $signed(dq_mag[DQW-1:0]);
        end else begin
            dq_o = (dq_mag > DMW'(32768)) ? 16'sh8000 : $signed(-dq_mag[DQW-1:0]);
        end
    end

endmodule

// File: rtl/quantize_block.sv
// Block quantizer: captures a coefficient block on start, quantizes one coefficient
// per cycle. Define QUANT_ZIGZAG_EN to emit outputs in zigzag scan order.
module quantize_block
    import quantize_block_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [(BIT_WIDTH+4)*BLOCK_SIZE*BLOCK_SIZE-1:0] coef_in,
    input  logic [QW-1:0]                            dc_q,
    input  logic [QW-1:0]                            ac_q,
    input  logic [IQW-1:0]                           dc_iq,
    input  logic [IQW-1:0]                           ac_iq,
    input  logic [IQW-1:0]                           bias,
    output logic [(BIT_WIDTH+4)*BLOCK_SIZE*BLOCK_SIZE-1:0] level_out,
    output logic [DQW*BLOCK_SIZE*BLOCK_SIZE-1:0]     dq_out,
    output logic [BLOCK_SIZE*BLOCK_SIZE-1:0]         nz_mask,
    output logic [4:0]                               last_idx,
    output logic                                     busy,
    output logic                                     done
);

    localparam int unsigned CW = BIT_WIDTH + 4;
    localparam int unsigned N  = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned IW = $clog2(N);

    state_e              state_q;
    logic [IW-1:0]       cnt_q;
    logic [CW*N-1:0]     coef_q;
    logic [QW-1:0]       dc_step_q, ac_step_q;
    logic [IQW-1:0]      dc_recip_q, ac_recip_q, bias_q;
    logic [CW*N-1:0]     level_q;
    logic [DQW*N-1:0]    dq_q;
    logic [N-1:0]        nz_q;
    logic [4:0]          last_q, last_d;
    logic                busy_q, done_q;

    logic [IW-1:0]       src_idx;
    logic signed [CW-1:0] cur_coef, cur_level;
    logic signed [DQW-1:0] cur_dq;
    logic [QW-1:0]       q_sel;
    logic [IQW-1:0]      iq_sel;
    logic                cur_nz;

    always_comb begin
`ifdef QUANT_ZIGZAG_EN
        src_idx = zigzag_src(cnt_q);
`else
        src_idx = cnt_q;
`endif
        cur_coef = $signed(coef_q[CW*src_idx +: CW]);
        q_sel    = (src_idx == '0) ? dc_step_q  : ac_step_q;
        iq_sel   = (src_idx == '0) ? dc_recip_q : ac_recip_q;
        cur_nz   = (cur_level != '0);

        // Index 0 restarts the running maximum so a previous block cannot leak in
        if (cnt_q == '0) begin
            last_d = cur_nz ? 5'd0 : 5'd31;
        end else begin
            last_d = cur_nz ? 5'(cnt_q) : last_q;
        end
    end

    quant_coef #(
        .CW(CW)
    ) u_quant_coef (
        .coef_i  (cur_coef),
        .q_i     (q_sel),
        .iq_i    (iq_sel),
        .bias_i  (bias_q),
        .level_o (cur_level),
        .dq_o    (cur_dq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            coef_q     <= '0;
            dc_step_q  <= '0;
            ac_step_q  <= '0;
            dc_recip_q <= '0;
            ac_recip_q <= '0;
            bias_q     <= '0;
            level_q    <= '0;
            dq_q       <= '0;
            nz_q       <= '0;
            last_q     <= 5'd31;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        coef_q     <= coef_in;
                        dc_step_q  <= dc_q;
                        ac_step_q  <= ac_q;
                        dc_recip_q <= dc_iq;
                        ac_recip_q <= ac_iq;
                        bias_q     <= bias;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    level_q[CW*cnt_q +: CW]  <= cur_level;
                    dq_q[DQW*cnt_q +: DQW]   <= cur_dq;
                    nz_q[cnt_q]              <= cur_nz;
                    last_q                   <= last_d;
                    if (cnt_q == IW'(N-1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign level_out = level_q;
    assign dq_out    = dq_q;
    assign nz_mask   = nz_q;
    assign last_idx  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_quantize_block.sv
// Self-checking bench for quantize_block: directed vector table, restart/reset
// sequences, and randomized blocks against an arithmetic reference model.
module tb_quantize_block;

    localparam int CW = 12;
    localparam int N  = 16;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [CW*N-1:0]   coef_in;
    logic [8:0]        dc_q, ac_q;
    logic [16:0]       dc_iq, ac_iq, bias;
    logic [CW*N-1:0]   level_out;
    logic [16*N-1:0]   dq_out;
    logic [N-1:0]      nz_mask;
    logic [4:0]        last_idx;
    logic              busy, done;

    quantize_block #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .coef_in(coef_in),
        .dc_q(dc_q), .ac_q(ac_q), .dc_iq(dc_iq), .ac_iq(ac_iq), .bias(bias),
        .level_out(level_out), .dq_out(dq_out), .nz_mask(nz_mask),
        .last_idx(last_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int c[16];
    int s_dcq, s_acq, s_dciq, s_aciq, s_bias;

    logic [CW*N-1:0] exp_level;
    logic [16*N-1:0] exp_dq;
    logic [N-1:0]    exp_nz;
    logic [4:0]      exp_last;

    typedef struct {
        int c0, c4;
        int dcq, dciq, acq, aciq, bias;
        int idx, lvl, dq, nz, last;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int src_of(input int k);
`ifdef QUANT_ZIGZAG_EN
        int scan[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
        return scan[k];
`else
        return k;
`endif
    endfunction

    function automatic void model();
        exp_last = 5'd31;
        exp_nz   = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            longint q, iq, mag, m, lv, d;
            s   = src_of(k);
            q   = (s == 0) ? s_dcq  : s_acq;
            iq  = (s == 0) ? s_dciq : s_aciq;
            mag = (c[s] < 0) ? -c[s] : c[s];
            m   = (mag * iq + s_bias) / 131072;
            if (m > 2047) m = 2047;
            lv  = (c[s] < 0) ? -m : m;
            if (c[s] == 0) lv = 0;
            d   = lv * q;
            if (d > 32767)  d = 32767;
            if (d < -32768) d = -32768;
            exp_level[CW*k +: CW] = 12'(lv);
            exp_dq[16*k +: 16]    = 16'(d);
            exp_nz[k]             = (lv != 0);
            if (lv != 0) exp_last = 5'(k);
        end
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) coef_in[CW*i +: CW] = 12'(c[i]);
        dc_q  = 9'(s_dcq);
        ac_q  = 9'(s_acq);
        dc_iq = 17'(s_dciq);
        ac_iq = 17'(s_aciq);
        bias  = 17'(s_bias);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) coef_in[CW*i +: CW] = 12'($urandom);
        dc_q  = 9'($urandom);
        ac_q  = 9'($urandom);
        dc_iq = 17'($urandom);
        ac_iq = 17'($urandom);
        bias  = 17'($urandom);
    endtask

    // restart_at > 0 pulses a second start with fresh inputs during that RUN cycle
    task automatic run_block(input int restart_at);
        int n;
        bit busy_ok, seen;
        @(negedge clk);
        apply_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        n = 0; busy_ok = 1'b1; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
            if (n == restart_at) begin
                start = 1'b1;
                scramble_inputs();
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 256'(seen), 256'(1));
        chk("done_cycle", 256'(n), 256'(17));
        chk("busy_during_run", 256'(busy_ok), 256'(1));
        chk("busy_low_at_done", 256'(busy), 256'(0));
        @(posedge clk); #1;
        chk("done_one_cycle", 256'(done), 256'(0));
    endtask

    task automatic check_model(input string tag);
        model();
        chk({tag, "_level"}, 256'(level_out), 256'(exp_level));
        chk({tag, "_dq"},    256'(dq_out),    256'(exp_dq));
        chk({tag, "_nz"},    256'(nz_mask),   256'(exp_nz));
        chk({tag, "_last"},  256'(last_idx),  256'(exp_last));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  256'(busy),      256'(0));
        chk({tag, "_done"},  256'(done),      256'(0));
        chk({tag, "_level"}, 256'(level_out), 256'(0));
        chk({tag, "_dq"},    256'(dq_out),    256'(0));
        chk({tag, "_nz"},    256'(nz_mask),   256'(0));
        chk({tag, "_last"},  256'(last_idx),  256'(31));
    endtask

    task automatic clear_c();
        for (int i = 0; i < N; i++) c[i] = 0;
    endtask

    initial begin
        vec_t vecs[7];
        int p4;
`ifdef QUANT_ZIGZAG_EN
        p4 = 2;
`else
        p4 = 4;
`endif
        vecs[0] = '{0,     0,    50, 2621,  50,  2621,   131071, 0,  0,     0,      0,       31};
        vecs[1] = '{100,   0,    10, 13107, 7,   18724,  65536,  0,  10,    100,    1,       0};
        vecs[2] = '{-100,  0,    10, 13107, 7,   18724,  65536,  0,  -10,   -100,   1,       0};
        vecs[3] = '{0,     2047, 10, 13107, 1,   131071, 2047,   p4, 2047,  2047,   1 << p4, p4};
        vecs[4] = '{0,     2047, 10, 13107, 300, 131071, 2047,   p4, 2047,  32767,  1 << p4, p4};
        vecs[5] = '{0,    -2048, 10, 13107, 300, 131071, 131071, p4, -2047, -32768, 1 << p4, p4};
        vecs[6] = '{-2048, 0,    16, 8192,  3,   43690,  0,      0,  -128,  -2048,  1,       0};

        rst = 1'b1; start = 1'b0;
        coef_in = '0; dc_q = '0; ac_q = '0; dc_iq = '0; ac_iq = '0; bias = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            logic [CW-1:0] el;
            logic [15:0]   ed;
            clear_c();
            c[0] = vecs[v].c0;
            c[4] = vecs[v].c4;
            s_dcq = vecs[v].dcq; s_dciq = vecs[v].dciq;
            s_acq = vecs[v].acq; s_aciq = vecs[v].aciq;
            s_bias = vecs[v].bias;
            run_block(0);
            el = 12'(vecs[v].lvl);
            ed = 16'(vecs[v].dq);
            chk($sformatf("vec%0d_level", v), 256'(level_out[CW*vecs[v].idx +: CW]), 256'(el));
            chk($sformatf("vec%0d_dq", v),    256'(dq_out[16*vecs[v].idx +: 16]),    256'(ed));
            chk($sformatf("vec%0d_nz", v),    256'(nz_mask),  256'(vecs[v].nz));
            chk($sformatf("vec%0d_last", v),  256'(last_idx), 256'(vecs[v].last));
            check_model($sformatf("vec%0d_model", v));
        end

        // Second start mid-RUN must be ignored
        clear_c();
        c[4] = 2047; c[1] = -37; c[9] = 500;
        s_dcq = 10; s_dciq = 13107; s_acq = 300; s_aciq = 131071; s_bias = 2047;
        run_block(5);
        check_model("restart");

        // Reset at RUN cycle 8 aborts the block
        for (int i = 0; i < N; i++) c[i] = $urandom_range(1, 2047);
        s_dcq = 4; s_dciq = 32768; s_acq = 5; s_aciq = 26214; s_bias = 65536;
        begin
            bit seen;
            @(negedge clk);
            apply_inputs();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            rst = 1'b1;
            #2;
            check_reset_state("abort");
            @(negedge clk);
            rst = 1'b0;
            seen = 1'b0;
            repeat (25) begin
                @(posedge clk); #1;
                if (done || busy) seen = 1'b1;
            end
            chk("abort_no_done", 256'(seen), 256'(0));
        end
        run_block(0);
        check_model("after_abort");

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: c[i] = 0;
                    1: c[i] = int'($urandom_range(0, 64)) - 32;
                    default: c[i] = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
            s_dcq = $urandom_range(1, 511);
            s_acq = $urandom_range(1, 511);
            s_dciq = (131072 / s_dcq > 131071) ? 131071 : 131072 / s_dcq;
            s_aciq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 131071))
                                                 : ((131072 / s_acq > 131071) ? 131071 : 131072 / s_acq);
            s_bias = $urandom_range(0, 131071);
            run_block(0);
            check_model($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
